// File: rtl/led_scheduler_pkg.sv
// Shared types and helpers for the LED display scheduler.
package led_sched_pkg;

  localparam int MAX_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot encode a requester index. Indices at or above n produce all zeros.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [1:0] idx, input int n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((i < n) && (idx == 2'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/led_scheduler_if.sv
// Requester-side handshake bundle: request levels, packed words, grant pulses.
interface led_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;

  modport master (output req, output req_data, input ack);
  modport slave  (input req, input req_data, output ack);
endinterface

// File: rtl/led_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request after 'last', wrapping.
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         gnt_idx,
  output logic               gnt_valid
);

  // Walk offsets 1..NUM_REQ from the previous winner; the first hit wins.
  always_comb begin
    int idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_valid && (idx == i) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = 2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Time-shares the LED display word between requesters with a minimum hold.
//
// state | meaning
// IDLE  | waiting for any request; grants on the first edge one is seen
// HOLD  | granted word is on display; counting down the hold time
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  led_scheduler_if.slave    bus,
  output logic [DATA_W-1:0] led_word,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [1:0]         rst_sync;
  logic               rst_int_n;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  led_q, led_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [1:0]         gnt_idx;
  logic               gnt_valid;
  logic [DATA_W-1:0]  words [NUM_REQ];

  // Assert reset immediately, release it two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (bus.req),
    .last      (last_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // State and output registers; led_word is only ever driven from here.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      led_q   <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: grant and capture in IDLE, count down in HOLD.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    ack_d   = '0;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 2'(i)) led_d = words[i];
          end
          ack_d   = NUM_REQ'(onehot(gnt_idx, NUM_REQ));
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack  = ack_q;
  assign led_word = led_q;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_scheduler.sv
// Directed bench: table of per-cycle vectors plus hand sequences for reset and HOLD_CYCLES=1.
module tb_led_scheduler;

  logic clk;
  logic rst_n;

  logic [31:0] led4, led1;
  logic [1:0]  own4, own1;
  logic        busy4, busy1;

  int vectors;
  int miscompares;

  led_scheduler_if #(.NUM_REQ(2), .DATA_W(32)) bus4 ();
  led_scheduler_if #(.NUM_REQ(2), .DATA_W(32)) bus1 ();

  led_scheduler #(.NUM_REQ(2), .DATA_W(32), .HOLD_CYCLES(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus4),
    .led_word (led4),
    .owner    (own4),
    .busy     (busy4)
  );

  led_scheduler #(.NUM_REQ(2), .DATA_W(32), .HOLD_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1),
    .led_word (led1),
    .owner    (own1),
    .busy     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ack;
    logic [31:0] led;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  vec_t tbl [31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] eack, input logic [31:0] eled,
                      input logic [1:0] eown, input logic ebusy);
    check($sformatf("%s ack", tag),   {30'b0, bus4.ack}, {30'b0, eack});
    check($sformatf("%s led", tag),   led4, eled);
    check($sformatf("%s owner", tag), {30'b0, own4}, {30'b0, eown});
    check($sformatf("%s busy", tag),  {31'b0, busy4}, {31'b0, ebusy});
  endtask

  task automatic chk1(input string tag, input logic [1:0] eack, input logic [31:0] eled,
                      input logic [1:0] eown, input logic ebusy);
    check($sformatf("%s ack", tag),   {30'b0, bus1.ack}, {30'b0, eack});
    check($sformatf("%s led", tag),   led1, eled);
    check($sformatf("%s owner", tag), {30'b0, own1}, {30'b0, eown});
    check($sformatf("%s busy", tag),  {31'b0, busy1}, {31'b0, ebusy});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // req, d0, d1 applied before the edge; ack, led, owner, busy expected after it.
    tbl[0]  = '{2'b01, 32'h0000_00A5, 32'h0, 2'b01, 32'h0000_00A5, 2'd0, 1'b1};
    tbl[1]  = '{2'b00, 32'h0000_00A5, 32'h0, 2'b00, 32'h0000_00A5, 2'd0, 1'b1};
    tbl[2]  = '{2'b00, 32'h0000_00A5, 32'h0, 2'b00, 32'h0000_00A5, 2'd0, 1'b1};
    tbl[3]  = '{2'b00, 32'h0000_00A5, 32'h0, 2'b00, 32'h0000_00A5, 2'd0, 1'b1};
    tbl[4]  = '{2'b00, 32'h0000_00A5, 32'h0, 2'b00, 32'h0000_00A5, 2'd0, 1'b0};
    tbl[5]  = '{2'b11, 32'h11, 32'h22, 2'b10, 32'h22, 2'd1, 1'b1};
    tbl[6]  = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[7]  = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[8]  = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[9]  = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b0};
    tbl[10] = '{2'b11, 32'h11, 32'h22, 2'b01, 32'h11, 2'd0, 1'b1};
    tbl[11] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[12] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[13] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[14] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h11, 2'd0, 1'b0};
    tbl[15] = '{2'b11, 32'h11, 32'h22, 2'b10, 32'h22, 2'd1, 1'b1};
    tbl[16] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[17] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[18] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b1};
    tbl[19] = '{2'b11, 32'h11, 32'h22, 2'b00, 32'h22, 2'd1, 1'b0};
    tbl[20] = '{2'b11, 32'h11, 32'h22, 2'b01, 32'h11, 2'd0, 1'b1};
    tbl[21] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[22] = '{2'b10, 32'hFF, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[23] = '{2'b10, 32'hFF, 32'h22, 2'b00, 32'h11, 2'd0, 1'b1};
    tbl[24] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'h11, 2'd0, 1'b0};
    tbl[25] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'h11, 2'd0, 1'b0};
    tbl[26] = '{2'b01, 32'hFF, 32'h22, 2'b01, 32'hFF, 2'd0, 1'b1};
    tbl[27] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'hFF, 2'd0, 1'b1};
    tbl[28] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'hFF, 2'd0, 1'b1};
    tbl[29] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'hFF, 2'd0, 1'b1};
    tbl[30] = '{2'b00, 32'hFF, 32'h22, 2'b00, 32'hFF, 2'd0, 1'b0};

    rst_n         = 1'b0;
    bus4.req      = '0;
    bus4.req_data = '0;
    bus1.req      = '0;
    bus1.req_data = '0;

    tick();
    tick();
    chk4("in_reset", 2'b00, 32'h0, 2'd0, 1'b0);
    chk1("in_reset_h1", 2'b00, 32'h0, 2'd0, 1'b0);

    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk4($sformatf("idle%0d", c), 2'b00, 32'h0, 2'd0, 1'b0);
    end

    for (int i = 0; i < 31; i++) begin
      bus4.req      = tbl[i].req;
      bus4.req_data = {tbl[i].d1, tbl[i].d0};
      tick();
      chk4($sformatf("vec%0d", i), tbl[i].ack, tbl[i].led, tbl[i].own, tbl[i].busy);
    end

    // Grant requester 1 with 0x22, then reset in the middle of its hold.
    bus4.req      = 2'b10;
    bus4.req_data = {32'h22, 32'hFF};
    tick();
    chk4("pre_rst_grant", 2'b10, 32'h22, 2'd1, 1'b1);
    bus4.req = 2'b00;
    tick();
    chk4("pre_rst_hold", 2'b00, 32'h22, 2'd1, 1'b1);
    rst_n         = 1'b0;
    bus4.req      = 2'b11;
    bus4.req_data = {32'h44, 32'h33};
    #1;
    chk4("async_rst", 2'b00, 32'h0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk4("rel_edge1", 2'b00, 32'h0, 2'd0, 1'b0);
    tick();
    chk4("rel_edge2", 2'b00, 32'h0, 2'd0, 1'b0);
    tick();
    chk4("post_rst_grant", 2'b01, 32'h33, 2'd0, 1'b1);
    bus4.req = 2'b00;

    // HOLD_CYCLES=1: a lone requester is granted every second cycle.
    for (int k = 0; k < 8; k++) begin
      bus1.req      = 2'b01;
      bus1.req_data = {32'h0, 32'h100 + 32'(k)};
      tick();
      if (k % 2 == 0)
        chk1($sformatf("h1_k%0d", k), 2'b01, 32'h100 + 32'(k), 2'd0, 1'b1);
      else
        chk1($sformatf("h1_k%0d", k), 2'b00, 32'h100 + 32'(k - 1), 2'd0, 1'b0);
    end
    bus1.req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_scheduler.md
Name: led_scheduler

Overview:
- Time-shares the 8-bit board LED display between NUM_REQ requesters, for example the CPU store path and the debug monitor.
- Each requester presents a 32-bit word with a req/ack handshake.
- A round-robin arbiter grants one requester and latches its word into the register that drives the LED block's 32-bit data input.
- The latched word is held for a minimum of HOLD_CYCLES clocks so it stays visible before the next grant.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- DATA_W, 32, width of each request word and of led_word.
- HOLD_CYCLES, 1024, minimum clocks a granted word stays on led_word; must be >= 1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, per-requester request level.
- req_data, input, NUM_REQ*DATA_W, packed request words; requester i occupies bits [i*DATA_W +: DATA_W].
- ack, output, NUM_REQ, one-hot grant pulse, one cycle wide.
- led_word, output, DATA_W, held display word; feeds the LED block's data input, which shows bits [7:0].
- owner, output, 2, index of the requester that last won a grant.
- busy, output, 1, high while in HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; led_word=0, ack=0, owner=0, busy=0, hold counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset deasserts synchronously internally: two-flop release of rst_n onto the internal reset net.
- FSM has two states, IDLE and HOLD.
- IDLE, no req bit set: all outputs hold their values; ack=0.
- IDLE, any req bit set: winner w = first set bit searching from last+1 upward, wrapping modulo NUM_REQ. At that clock edge:
  - led_word<=req_data[w]
  - ack<=onehot(w)
  - owner<=w
  - last<=w
  - cnt<=HOLD_CYCLES-1
  - busy<=1
  - state<=HOLD
- Latency: req sampled high in IDLE at edge N gives ack and the new led_word visible after edge N, i.e. in cycle N+1.
- ack lasts exactly one cycle. It is forced to 0 on every cycle other than the grant edge.
- HOLD:
  - ack=0. req is ignored and no word is captured.
  - If cnt!=0, cnt decrements.
  - If cnt==0, the next edge gives state<=IDLE and busy<=0.
  - A HOLD_CYCLES=1 grant therefore spends 1 cycle in HOLD. Grant-to-grant minimum is HOLD_CYCLES+1 cycles.
- Handshake rules:
  - A requester keeps req and req_data stable until it sees its ack bit. It drops req in the cycle after ack unless it has another word to display.
  - req deasserted before ack: the request is withdrawn and nothing is latched.
  - req_data is sampled only on the grant edge; changes at other times have no effect.
- Fairness:
  - A requester that still holds req after its grant can win again only after every other asserted requester has been served.
  - With a single active requester, it is re-granted every HOLD_CYCLES+1 cycles.
- Simultaneous requests in IDLE: exactly one grant, chosen by the round-robin order; the others wait.
- Reset mid-HOLD: immediate return to the reset values, including led_word=0. The pending ack is lost.
- Width rules:
  - cnt width = $clog2(HOLD_CYCLES+1).
  - owner is zero-extended to 2 bits.
  - req bits at index >= NUM_REQ do not exist. The arbiter search covers only 0..NUM_REQ-1.
- led_word is driven only from a register; there is no combinational path from req_data.

Decomposition:
- Shared package led_sched_pkg contains:
  - state typedef {IDLE, HOLD}.
  - Constant MAX_REQ=4.
  - Function onehot(idx, n).
- One sub-module: rr_arbiter.
  - Ports: req[NUM_REQ], last[1:0], gnt_idx[1:0], gnt_valid.
  - Purely combinational round-robin search.
  - The FSM, counter and output registers stay in led_scheduler.

Test Plan (NUM_REQ=2, HOLD_CYCLES=4 unless noted):
- Reset release, no req -> led_word=0, ack=00, owner=0 and busy=0 held for 20 cycles.
- req=01, req_data0=0x0000_00A5 in IDLE -> next cycle ack=01, led_word=0x0000_00A5, owner=0, busy=1; busy falls 4 cycles later.
- req=11 held continuously, data0=0x11, data1=0x22 -> grants alternate 0,1,0,1 every 5 cycles; led_word alternates 0x11/0x22; ack never has 2 bits set.
- req=01 held alone with HOLD_CYCLES=1 -> ack=01 every 2nd cycle; led_word is updated only on ack cycles.
- During HOLD, change req_data0 to 0xFF and pulse req1 for 2 cycles only -> led_word unchanged until the hold ends; no grant to requester 1.
- Assert rst_n=0 for 1 cycle mid-HOLD with led_word=0x22 -> led_word=0, busy=0 and ack=00 immediately (asynchronous); next request goes to requester 0 first.
